// File: rtl/cis_scan_sequencer.sv
// -----------------------------------------------------------------------------
// cis_scan_sequencer
//
// Runs a finite scan job on the CIS controller in event mode. Each RGB triplet
// is requested with one EXTERNAL_START pulse. Pulses are spaced by a
// programmable period, clamped to a minimum, and are held back while the
// downstream line buffer is almost full. Completed triplets are counted from
// the controller's SI_TOGGLE / SI_CNT outputs. A triplet that never completes
// ends the job with a sticky timeout flag.
//
// Ports:
//   CLK          system clock
//   RST          synchronous reset, active low
//   CMD_START    one-cycle pulse, starts a job (only accepted while idle)
//   CMD_ABORT    one-cycle pulse, cancels the running job without DONE
//   LINE_TOTAL   triplets to acquire (latched at start)
//   LINE_PERIOD  clocks between trigger rises (latched at start, clamped)
//   FIFO_AFULL   downstream buffer almost full, holds the next trigger
//   SI_TOGGLE    toggles at each line start (from CIS controller)
//   SI_CNT       colour index of the line just started, 0=R 1=G 2=B
//   MODE         CIS controller mode, MODE_IDLE while not busy
//   EXT_START    CIS controller EXTERNAL_START
//   BUSY         job in progress
//   DONE         one-cycle pulse at job end (normal or timeout)
//   ERR_TIMEOUT  sticky timeout flag, cleared by the next accepted start
//   LINES_DONE   triplets completed in the current / last job
// -----------------------------------------------------------------------------
module cis_scan_sequencer #(
    parameter int                   CNT_WIDTH       = 24,
    parameter int                   LINES_WIDTH     = 16,
    parameter logic [CNT_WIDTH-1:0] PERIOD_MIN      = 24'd8064,
    parameter int                   START_PULSE_LEN = 4,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYC     = 24'd100000,
    parameter logic [1:0]           MODE_IDLE       = 2'd0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CMD_START,
    input  logic                   CMD_ABORT,
    input  logic [LINES_WIDTH-1:0] LINE_TOTAL,
    input  logic [CNT_WIDTH-1:0]   LINE_PERIOD,
    input  logic                   FIFO_AFULL,
    input  logic                   SI_TOGGLE,
    input  logic [1:0]             SI_CNT,
    output logic [1:0]             MODE,
    output logic                   EXT_START,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR_TIMEOUT,
    output logic [LINES_WIDTH-1:0] LINES_DONE
);

    localparam logic [1:0]           MODE_EVENT  = 2'd2;
    localparam logic [3:0]           PULSE_LAST  = 4'(START_PULSE_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST    = TIMEOUT_CYC - CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TRIG,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [LINES_WIDTH-1:0] total_lat;
    logic [CNT_WIDTH-1:0]   period_lat;
    logic [CNT_WIDTH-1:0]   period_clamped;
    logic [CNT_WIDTH-1:0]   per_cnt;
    logic [CNT_WIDTH-1:0]   tmo_cnt;
    logic [3:0]             pulse_cnt;
    logic                   tgl_d;
    logic                   trig_evt;
    logic                   zero_pend;

    logic                   start_ok;
    logic                   triplet;
    logic                   evt_count;
    logic                   period_ok;
    logic                   pulse_last;
    logic                   timeout_hit;
    logic [LINES_WIDTH-1:0] lines_inc;
    logic [LINES_WIDTH-1:0] lines_after;

    assign period_clamped = (LINE_PERIOD < PERIOD_MIN) ? PERIOD_MIN : LINE_PERIOD;

    // A zero-length job stays in IDLE for one cycle to emit its DONE pulse;
    // a second start in that cycle is not taken.
    assign start_ok  = (state == S_IDLE) && CMD_START && !CMD_ABORT && !zero_pend;

    // A triplet ends when the controller wraps from B back to R.
    assign triplet   = (SI_TOGGLE ^ tgl_d) && (SI_CNT == 2'd0);
    assign evt_count = triplet && ((state == S_TRIG) || (state == S_WAIT));

    // per_cnt reads 0 in the cycle EXT_START rises, so reaching period-1 here
    // puts the next rise exactly one period after the previous one.
    assign period_ok   = ({1'b0, per_cnt} + (CNT_WIDTH+1)'(1)) >= {1'b0, period_lat};
    assign pulse_last  = (pulse_cnt == PULSE_LAST);
    assign lines_inc   = LINES_DONE + LINES_WIDTH'(1);
    assign lines_after = triplet ? lines_inc : LINES_DONE;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_ok && (LINE_TOTAL != '0)) begin
                    next_state = S_ARM;
                end
            end
            S_ARM: begin
                if (CMD_ABORT) begin
                    next_state = S_IDLE;
                end else if (period_ok && !FIFO_AFULL) begin
                    next_state = S_TRIG;
                end
            end
            S_TRIG: begin
                if (CMD_ABORT) begin
                    next_state = S_IDLE;
                end else if (pulse_last) begin
                    // A triplet already seen during the pulse needs no wait.
                    if (trig_evt || triplet) begin
                        next_state = (lines_after == total_lat) ? S_DONE : S_ARM;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (CMD_ABORT) begin
                    next_state = S_IDLE;
                end else if (triplet) begin
                    // The event wins over a timeout in the same cycle.
                    next_state = (lines_inc == total_lat) ? S_DONE : S_ARM;
                end else if (tmo_cnt == TMO_LAST) begin
                    next_state  = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            MODE        <= MODE_IDLE;
            EXT_START   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            LINES_DONE  <= '0;
            total_lat   <= '0;
            period_lat  <= '0;
            per_cnt     <= '0;
            tmo_cnt     <= '0;
            pulse_cnt   <= '0;
            trig_evt    <= 1'b0;
            zero_pend   <= 1'b0;
            // Loaded from the pin so a stale level is not seen as an edge.
            tgl_d       <= SI_TOGGLE;
        end else begin
            state     <= next_state;
            tgl_d     <= SI_TOGGLE;

            // Outputs are decoded from next_state so they line up with state.
            EXT_START <= (next_state == S_TRIG);
            BUSY      <= (next_state != S_IDLE);
            MODE      <= (next_state != S_IDLE) ? MODE_EVENT : MODE_IDLE;
            DONE      <= (next_state == S_DONE) || zero_pend;
            zero_pend <= start_ok && (LINE_TOTAL == '0);

            if (start_ok) begin
                total_lat   <= LINE_TOTAL;
                period_lat  <= period_clamped;
                LINES_DONE  <= '0;
                ERR_TIMEOUT <= 1'b0;
            end else begin
                if (evt_count) begin
                    LINES_DONE <= lines_inc;
                end
                if (timeout_hit) begin
                    ERR_TIMEOUT <= 1'b1;
                end
            end

            // Preset at start so the first trigger goes out without delay.
            if (start_ok) begin
                per_cnt <= period_clamped;
            end else if ((state == S_ARM) && (next_state == S_TRIG)) begin
                per_cnt <= '0;
            end else if (per_cnt < period_lat) begin
                per_cnt <= per_cnt + CNT_WIDTH'(1);
            end

            pulse_cnt <= (state == S_TRIG) ? pulse_cnt + 4'd1 : 4'd0;
            tmo_cnt   <= (state == S_WAIT) ? tmo_cnt + CNT_WIDTH'(1) : '0;
            trig_evt  <= (state == S_TRIG) && (trig_evt || triplet);
        end
    end

endmodule

// File: tb/tb_cis_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cis_scan_sequencer
//
// Self-checking bench for cis_scan_sequencer. A small CIS controller model
// answers each EXT_START rise with three line starts (G, B, wrap to R) and
// pushes the expected LINES_DONE value to a scoreboard queue; a monitor pops
// and compares whenever LINES_DONE advances. Whole jobs come from a table of
// scenarios; abort and reset corner cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_cis_scan_sequencer;

    localparam int          TMO        = 1000;
    localparam int          PULSE_LEN  = 4;
    localparam int          PERIOD     = 8064;
    localparam int          JOB_BUDGET = 40000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_START = 1'b0;
    logic        CMD_ABORT = 1'b0;
    logic [15:0] LINE_TOTAL = '0;
    logic [23:0] LINE_PERIOD = '0;
    logic        FIFO_AFULL = 1'b0;
    logic        SI_TOGGLE = 1'b0;
    logic [1:0]  SI_CNT = 2'd0;
    logic [1:0]  MODE;
    logic        EXT_START;
    logic        BUSY;
    logic        DONE;
    logic        ERR_TIMEOUT;
    logic [15:0] LINES_DONE;

    int          n_tests = 0;
    int          n_fail = 0;
    int          model_lim = 0;
    int          exp_cnt = 0;
    logic [15:0] sb_q[$];
    logic [15:0] ld_prev = '0;

    cis_scan_sequencer #(
        .TIMEOUT_CYC (24'd1000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CMD_START   (CMD_START),
        .CMD_ABORT   (CMD_ABORT),
        .LINE_TOTAL  (LINE_TOTAL),
        .LINE_PERIOD (LINE_PERIOD),
        .FIFO_AFULL  (FIFO_AFULL),
        .SI_TOGGLE   (SI_TOGGLE),
        .SI_CNT      (SI_CNT),
        .MODE        (MODE),
        .EXT_START   (EXT_START),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .LINES_DONE  (LINES_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] total;
        logic [23:0] period;
        int          afull_hold;  // cycles of FIFO_AFULL after the first triplet
        int          model_lim;   // triplets the model completes
        bit          poke;        // extra CMD_START while in ARM
        int          exp_trigs;
        logic [15:0] exp_lines;
        bit          exp_err;
        int          exp_gap;     // rise-to-rise spacing, 0 = released by FIFO
    } job_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expire(input string name, input int cycles);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no DUT response within %0d cycles", name, cycles);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // CIS controller model: three line starts per trigger, last one wraps to R.
    initial begin
        forever begin
            @(posedge EXT_START);
            if (exp_cnt < model_lim) begin
                repeat (40) @(posedge CLK);
                #1 SI_CNT = 2'd1; SI_TOGGLE = ~SI_TOGGLE;
                repeat (40) @(posedge CLK);
                #1 SI_CNT = 2'd2; SI_TOGGLE = ~SI_TOGGLE;
                repeat (40) @(posedge CLK);
                #1 SI_CNT = 2'd0; SI_TOGGLE = ~SI_TOGGLE;
                exp_cnt++;
                sb_q.push_back(16'(exp_cnt));
            end
        end
    end

    // Scoreboard monitor: every advance of LINES_DONE must match the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && LINES_DONE !== ld_prev && LINES_DONE !== 16'd0) begin
                if (sb_q.size() == 0) begin
                    check("lines_unexpected", LINES_DONE, ld_prev);
                end else begin
                    check("lines_done_sb", LINES_DONE, sb_q.pop_front());
                end
            end
            ld_prev = LINES_DONE;
        end
    end

    task automatic run_job(input job_t j);
        int cyc, rises, last_rise, hi_len, done_cnt, done_cyc, fall_cyc;
        int afull_left, afull_fall_cyc;
        bit ext_prev, busy_seen, err_seen, afull_req, afull_used, finished;
        cyc = 0; rises = 0; last_rise = 0; hi_len = 0; done_cnt = 0;
        done_cyc = -1; fall_cyc = -1; afull_left = 0; afull_fall_cyc = -100;
        ext_prev = 0; busy_seen = 0; err_seen = 0; afull_req = 0;
        afull_used = 0; finished = 0;
        model_lim = j.model_lim;
        exp_cnt = 0;

        tick(); LINE_TOTAL = j.total; LINE_PERIOD = j.period; CMD_START = 1'b1;  // cycle 0
        tick(); CMD_START = 1'b0; LINE_TOTAL = 16'hFFFF; LINE_PERIOD = 24'd20;  // cycle 1
        cyc = 1;
        while (!finished) begin
            @(negedge CLK);
            if (cyc == 1) begin
                check({j.name, "_err_cleared"}, ERR_TIMEOUT, 0);
                check({j.name, "_lines_cleared"}, LINES_DONE, 0);
                check({j.name, "_busy_c1"}, BUSY, (j.total != 0));
            end
            if (EXT_START && !ext_prev) begin
                rises++;
                if (rises == 1) begin
                    check({j.name, "_first_rise_lat"}, cyc, 2);
                    check({j.name, "_mode_event"}, MODE, 2);
                end else if (j.exp_gap > 0) begin
                    check({j.name, "_rise_gap"}, cyc - last_rise, j.exp_gap);
                end else begin
                    check({j.name, "_afull_release"}, cyc, afull_fall_cyc + 1);
                end
                last_rise = cyc;
                hi_len = 1;
            end else if (EXT_START) begin
                hi_len++;
            end else if (ext_prev) begin
                check({j.name, "_pulse_len"}, hi_len, PULSE_LEN);
                fall_cyc = cyc;
            end
            ext_prev  = EXT_START;
            busy_seen = busy_seen | BUSY;
            err_seen  = err_seen | ERR_TIMEOUT;
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (j.afull_hold > 0 && !afull_used && LINES_DONE == 16'd1) begin
                afull_req = 1;
                afull_used = 1;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) begin
                finished = 1;
            end else if (cyc >= JOB_BUDGET) begin
                expire({j.name, "_job_budget"}, cyc);
                finished = 1;
            end
            if (!finished) begin
                tick();
                cyc++;
                if (afull_left > 0) begin
                    afull_left--;
                    if (afull_left == 0) begin
                        FIFO_AFULL = 1'b0;
                        afull_fall_cyc = cyc;
                    end
                end else if (afull_req) begin
                    FIFO_AFULL = 1'b1;
                    afull_left = j.afull_hold;
                    afull_req = 0;
                end
                if (j.poke && cyc == 1002) begin
                    CMD_START = 1'b1;
                    LINE_TOTAL = 16'd1;
                end else begin
                    CMD_START = 1'b0;
                end
            end
        end
        FIFO_AFULL = 1'b0;
        check({j.name, "_trig_count"}, rises, j.exp_trigs);
        check({j.name, "_done_pulses"}, done_cnt, 1);
        check({j.name, "_lines_final"}, LINES_DONE, j.exp_lines);
        check({j.name, "_err_final"}, ERR_TIMEOUT, j.exp_err);
        check({j.name, "_err_seen"}, err_seen, j.exp_err);
        check({j.name, "_busy_seen"}, busy_seen, (j.total != 0));
        check({j.name, "_busy_after"}, BUSY, 0);
        check({j.name, "_mode_after"}, MODE, 0);
        check({j.name, "_sb_drained"}, sb_q.size(), 0);
        if (j.total == 0) check({j.name, "_done_latency"}, done_cyc, 2);
        if (j.exp_err) check({j.name, "_timeout_latency"}, done_cyc - fall_cyc, TMO);
    endtask

    initial begin
        job_t jobs[5];
        int   rises, cyc;
        bit   ext_prev, done_seen, ext_seen, busy_seen;

        jobs[0] = '{"normal3", 16'd3, 24'd100, 0,     3, 1'b1, 3, 16'd3, 1'b0, PERIOD};
        jobs[1] = '{"zero",    16'd0, 24'd100, 0,     0, 1'b0, 0, 16'd0, 1'b0, PERIOD};
        jobs[2] = '{"afull",   16'd2, 24'd100, 20000, 2, 1'b0, 2, 16'd2, 1'b0, 0};
        jobs[3] = '{"timeout", 16'd1, 24'd100, 0,     0, 1'b0, 1, 16'd0, 1'b1, PERIOD};
        jobs[4] = '{"after_to",16'd1, 24'd100, 0,     1, 1'b0, 1, 16'd1, 1'b0, PERIOD};

        // Reset state
        tick(); tick(); tick();
        @(negedge CLK);
        check("rst_mode", MODE, 0);
        check("rst_ext_start", EXT_START, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR_TIMEOUT, 0);
        check("rst_lines", LINES_DONE, 0);
        tick(); RST = 1'b1;
        tick();

        foreach (jobs[i]) run_job(jobs[i]);

        // Abort on the second cycle of EXT_START
        model_lim = 0; exp_cnt = 0;
        tick(); LINE_TOTAL = 16'd3; LINE_PERIOD = 24'd100; CMD_START = 1'b1;  // cycle 0
        tick(); CMD_START = 1'b0;                                             // cycle 1
        tick();                                                               // cycle 2
        @(negedge CLK);
        check("abort_ext_first", EXT_START, 1);
        tick(); CMD_ABORT = 1'b1;                                             // cycle 3
        @(negedge CLK);
        check("abort_ext_second", EXT_START, 1);
        tick(); CMD_ABORT = 1'b0;                                             // cycle 4
        @(negedge CLK);
        check("abort_ext_low", EXT_START, 0);
        check("abort_busy", BUSY, 0);
        check("abort_mode", MODE, 0);
        done_seen = 0; ext_seen = 0;
        repeat (20) begin
            tick();
            @(negedge CLK);
            done_seen = done_seen | DONE;
            ext_seen  = ext_seen | EXT_START;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_no_retrigger", ext_seen, 0);
        check("abort_lines_held", LINES_DONE, 0);

        // Start and abort together: no job
        tick(); LINE_TOTAL = 16'd2; CMD_START = 1'b1; CMD_ABORT = 1'b1;
        tick(); CMD_START = 1'b0; CMD_ABORT = 1'b0;
        done_seen = 0; ext_seen = 0; busy_seen = 0;
        repeat (20) begin
            @(negedge CLK);
            done_seen = done_seen | DONE;
            ext_seen  = ext_seen | EXT_START;
            busy_seen = busy_seen | BUSY;
            tick();
        end
        check("startabort_no_busy", busy_seen, 0);
        check("startabort_no_ext", ext_seen, 0);
        check("startabort_no_done", done_seen, 0);

        // Reset during WAIT_LINE with five triplets done
        model_lim = 5; exp_cnt = 0;
        tick(); LINE_TOTAL = 16'd8; LINE_PERIOD = 24'd100; CMD_START = 1'b1;
        tick(); CMD_START = 1'b0;
        rises = 0; ext_prev = 0; cyc = 0;
        while (rises < 6 && cyc < 50000) begin
            @(negedge CLK);
            if (EXT_START && !ext_prev) rises++;
            ext_prev = EXT_START;
            tick();
            cyc++;
        end
        if (rises < 6) expire("rst_reach_wait", cyc);
        repeat (10) tick();
        @(negedge CLK);
        check("rst_pre_lines", LINES_DONE, 5);
        check("rst_pre_busy", BUSY, 1);
        tick(); RST = 1'b0;
        tick(); RST = 1'b1;
        @(negedge CLK);
        check("midrst_mode", MODE, 0);
        check("midrst_ext", EXT_START, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        check("midrst_err", ERR_TIMEOUT, 0);
        check("midrst_lines", LINES_DONE, 0);
        done_seen = 0;
        repeat (20) begin
            tick();
            @(negedge CLK);
            done_seen = done_seen | DONE;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cis_scan_sequencer.md
Name: cis_scan_sequencer

Overview:
Sequences a finite scan job on the CIS controller. The block runs it in event mode: it issues one EXTERNAL_START trigger per RGB triplet, paces triggers by a programmable period, and holds triggers while the downstream line buffer is almost full. It counts completed triplets from the controller's SI_TOGGLE/SI_CNT outputs and reports busy, done, progress and timeout status to the host register block.

Parameters:
CNT_WIDTH, 24, width of period and timeout counters
LINES_WIDTH, 16, width of line total and line counters
PERIOD_MIN, 24'd8064, minimum trigger period in clocks (3 x 2688)
START_PULSE_LEN, 4, EXT_START high time in clocks (1..15)
TIMEOUT_CYC, 24'd100000, max clocks from trigger to triplet completion
MODE_IDLE, 2'd0, MODE driven while not busy

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-low (reset when RST==0)
CMD_START  in  1  one-cycle pulse, starts job
CMD_ABORT  in  1  one-cycle pulse, cancels job
LINE_TOTAL  in  LINES_WIDTH  RGB triplets to acquire
LINE_PERIOD  in  CNT_WIDTH  clocks between trigger starts
FIFO_AFULL  in  1  downstream buffer almost full, level
SI_TOGGLE  in  1  from CIS controller, toggles at each line start
SI_CNT  in  2  from CIS controller, colour index 0=R,1=G,2=B
MODE  out  2  to CIS controller MODE
EXT_START  out  1  to CIS controller EXTERNAL_START
BUSY  out  1  job in progress
DONE  out  1  one-cycle pulse at job end (normal or timeout)
ERR_TIMEOUT  out  1  sticky, set on timeout, cleared by next accepted CMD_START
LINES_DONE  out  LINES_WIDTH  triplets completed in current/last job

Behaviour:
- Reset (RST==0 at posedge): state IDLE; MODE=MODE_IDLE; EXT_START=0; BUSY=0; DONE=0; ERR_TIMEOUT=0; LINES_DONE=0; all counters 0; SI_TOGGLE history register loaded from SI_TOGGLE.
- All outputs are registered. A reset asserted mid-job returns to IDLE on that edge, with no DONE pulse.
- Config latch: on an accepted CMD_START, capture LINE_TOTAL. Capture LINE_PERIOD clamped to max(LINE_PERIOD, PERIOD_MIN). Clear LINES_DONE and ERR_TIMEOUT. Later input changes are ignored until the next job.
- Triplet event: tgl_edge = SI_TOGGLE ^ SI_TOGGLE_d. A triplet is complete when tgl_edge==1 and SI_CNT==2'd0 in the same cycle (wrap B->R). Such an event counts only in states TRIG and WAIT_LINE.
- Period timer: cleared in the cycle EXT_START rises, then increments and saturates at the clamped period.
- States:
  - IDLE: BUSY=0, MODE=MODE_IDLE. On CMD_START=1 with CMD_ABORT=0:
    - latched total==0: stay IDLE, pulse DONE next cycle, no trigger.
    - otherwise go to ARM, with the period timer preset to the clamped period so the first trigger is not delayed.
    - CMD_START while not IDLE is ignored.
  - ARM: BUSY=1, MODE=2'd2. Go to TRIG when the period timer >= clamped period and FIFO_AFULL==0. FIFO_AFULL holds ARM indefinitely without timeout.
  - TRIG: EXT_START=1 for exactly START_PULSE_LEN cycles. The timeout counter is cleared at entry. Then go to WAIT_LINE.
  - WAIT_LINE: EXT_START=0; the timeout counter increments.
    - On a triplet event, LINES_DONE+1. If the new LINES_DONE==latched total, go to DONE; else go to ARM.
    - If the timeout counter reaches TIMEOUT_CYC-1 with no event: set ERR_TIMEOUT, go to DONE.
    - Event and timeout in the same cycle: the event wins, with no error.
  - DONE: one cycle, DONE=1, BUSY=0 on the next cycle, then go to IDLE.
- CMD_ABORT in ARM/TRIG/WAIT_LINE: next cycle state IDLE, EXT_START=0 (the pulse is truncated), BUSY=0, MODE=MODE_IDLE. No DONE pulse; LINES_DONE is held.
- CMD_ABORT and CMD_START together in IDLE: the job does not start.
- A triplet event in the same cycle as an abort still increments LINES_DONE.
- LINES_DONE never wraps: the job ends at the latched total, and totals up to 2^LINES_WIDTH-1 are supported.
- Latency: CMD_START to the first EXT_START rise is 2 cycles when FIFO_AFULL==0.

Test Plan:
- LINE_TOTAL=3, LINE_PERIOD=100 (clamped to 8064), model toggles SI 3x per trigger -> three 4-cycle EXT_START pulses, rises exactly 8064 clocks apart, LINES_DONE 1,2,3, one DONE pulse, BUSY low after.
- LINE_TOTAL=0 -> no EXT_START, DONE pulse 2 cycles after CMD_START, BUSY never high, LINES_DONE=0.
- FIFO_AFULL held high for 20000 clocks after the first triplet, LINE_TOTAL=2 -> second trigger occurs the cycle after FIFO_AFULL falls, ERR_TIMEOUT stays 0.
- Model stops toggling after the first trigger, TIMEOUT_CYC=1000 -> ERR_TIMEOUT=1 and DONE exactly 1000 cycles after TRIG exit, LINES_DONE=0. Next CMD_START clears ERR_TIMEOUT.
- CMD_ABORT on the 2nd cycle of EXT_START -> EXT_START low next cycle, BUSY=0, no DONE, MODE=MODE_IDLE; CMD_START+CMD_ABORT together -> no start.
- RST=0 during WAIT_LINE with LINES_DONE=5 -> all outputs at reset values on the next edge, no DONE. CMD_START during ARM -> ignored, latched total unchanged.
